// File: rtl/gray_pkg.sv
// Shared definitions for Gray-code consumers: code width, monitor state
// encoding and small conversion/counting helpers.
package gray_pkg;

    localparam int GRAY_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    function automatic logic [GRAY_W-1:0] g2b(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Callers zero-extend narrower vectors into the 32-bit argument.
    function automatic logic [5:0] popcount(input logic [31:0] x);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, x[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_monitor_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Bin
);

    // Prefix XOR from the MSB down, written without self-reference.
    always_comb begin
        Bin = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            Bin[i] = ^(Gray >> i);
        end
    end

endmodule

// File: rtl/gray_monitor.sv
// Consumer of the upstream Gray counter: converts samples to binary, polices
// the single-bit-step rule and counts legal wraps against the Overflow flag.
module gray_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W,
    parameter int LAP_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Gray_in,
    input  logic             Ovf_in,
    input  logic             Clear,
    output logic [WIDTH-1:0] Binary,
    output logic             Locked,
    output logic             Step_err,
    output logic             Err_sticky,
    output logic             Ovf_mismatch,
    output logic [LAP_W-1:0] Lap_cnt
);

    localparam logic [WIDTH-1:0] MAX_BIN  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_BIN = {WIDTH{1'b0}};
    localparam logic [LAP_W-1:0] LAP_MAX  = {LAP_W{1'b1}};

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] last_gray_r, last_gray_nxt_s;
    logic [WIDTH-1:0] binary_r, binary_nxt_s;
    logic [WIDTH-1:0] bin_in_s;
    logic [LAP_W-1:0] lap_cnt_r, lap_cnt_nxt_s;
    logic             step_err_r, step_err_nxt_s;
    logic             err_sticky_r, err_sticky_nxt_s;
    logic             ovf_mismatch_r, ovf_mismatch_nxt_s;
    logic             locked_r;
    logic [5:0]       dist_s;
    logic             wrap_s;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .Gray (Gray_in),
        .Bin  (bin_in_s)
    );

    // Hamming distance to the last accepted sample and max->0 wrap detection.
    always_comb begin
        dist_s = popcount({{(32-WIDTH){1'b0}}, Gray_in ^ last_gray_r});
        wrap_s = (binary_r == MAX_BIN) && (bin_in_s == ZERO_BIN);
    end

    // Next-state and next-flag logic; Step_err falls back to 0 every cycle.
    always_comb begin
        state_nxt_s        = state_r;
        last_gray_nxt_s    = last_gray_r;
        binary_nxt_s       = binary_r;
        lap_cnt_nxt_s      = lap_cnt_r;
        err_sticky_nxt_s   = err_sticky_r;
        ovf_mismatch_nxt_s = ovf_mismatch_r;
        step_err_nxt_s     = 1'b0;
        if (Valid) begin
            case (state_r)
                IDLE: begin
                    last_gray_nxt_s = Gray_in;
                    binary_nxt_s    = bin_in_s;
                    state_nxt_s     = TRACK;
                end
                TRACK: begin
                    if (dist_s == 6'd1) begin
                        last_gray_nxt_s = Gray_in;
                        binary_nxt_s    = bin_in_s;
                        if (wrap_s) begin
                            if (lap_cnt_r != LAP_MAX) begin
                                lap_cnt_nxt_s = lap_cnt_r + LAP_W'(1);
                            end else begin
                                lap_cnt_nxt_s = lap_cnt_r;
                            end
                            if (!Ovf_in) begin
                                ovf_mismatch_nxt_s = 1'b1;
                            end else begin
                                ovf_mismatch_nxt_s = ovf_mismatch_r;
                            end
                        end else begin
                            lap_cnt_nxt_s = lap_cnt_r;
                        end
                    end else if (dist_s > 6'd1) begin
                        step_err_nxt_s   = 1'b1;
                        err_sticky_nxt_s = 1'b1;
                        state_nxt_s      = ERROR;
                    end else begin
                        state_nxt_s = TRACK;
                    end
                end
                ERROR: begin
                    state_nxt_s = ERROR;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers; Clear mirrors Reset but keeps Binary.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r        <= IDLE;
            last_gray_r    <= ZERO_BIN;
            binary_r       <= ZERO_BIN;
            lap_cnt_r      <= {LAP_W{1'b0}};
            step_err_r     <= 1'b0;
            err_sticky_r   <= 1'b0;
            ovf_mismatch_r <= 1'b0;
            locked_r       <= 1'b0;
        end else if (Clear) begin
            state_r        <= IDLE;
            last_gray_r    <= ZERO_BIN;
            binary_r       <= binary_r;
            lap_cnt_r      <= {LAP_W{1'b0}};
            step_err_r     <= 1'b0;
            err_sticky_r   <= 1'b0;
            ovf_mismatch_r <= 1'b0;
            locked_r       <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            last_gray_r    <= last_gray_nxt_s;
            binary_r       <= binary_nxt_s;
            lap_cnt_r      <= lap_cnt_nxt_s;
            step_err_r     <= step_err_nxt_s;
            err_sticky_r   <= err_sticky_nxt_s;
            ovf_mismatch_r <= ovf_mismatch_nxt_s;
            locked_r       <= (state_nxt_s == TRACK);
        end
    end

    assign Binary       = binary_r;
    assign Locked       = locked_r;
    assign Step_err     = step_err_r;
    assign Err_sticky   = err_sticky_r;
    assign Ovf_mismatch = ovf_mismatch_r;
    assign Lap_cnt      = lap_cnt_r;

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor (LAP_W=2): a behavioural model queues the
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_gray_monitor;

    logic       Clk;
    logic       Reset;
    logic       Valid;
    logic [2:0] Gray_in;
    logic       Ovf_in;
    logic       Clear;
    logic [2:0] Binary;
    logic       Locked;
    logic       Step_err;
    logic       Err_sticky;
    logic       Ovf_mismatch;
    logic [1:0] Lap_cnt;

    gray_monitor #(.WIDTH(3), .LAP_W(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Valid        (Valid),
        .Gray_in      (Gray_in),
        .Ovf_in       (Ovf_in),
        .Clear        (Clear),
        .Binary       (Binary),
        .Locked       (Locked),
        .Step_err     (Step_err),
        .Err_sticky   (Err_sticky),
        .Ovf_mismatch (Ovf_mismatch),
        .Lap_cnt      (Lap_cnt)
    );

    typedef struct {
        int bin;
        int locked;
        int step;
        int err;
        int ovfm;
        int lap;
    } exp_t;

    exp_t exp_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;

    // Reference model state: 0=IDLE 1=TRACK 2=ERROR.
    int m_state = 0;
    int m_last  = 0;
    int m_bin   = 0;
    int m_lap   = 0;
    int m_err   = 0;
    int m_ovfm  = 0;
    int m_step  = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk_eq(input string tag, input int obs, input int exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Binary value found by searching for the code whose Gray image matches.
    function automatic int ref_bin(input int g);
        for (int b = 0; b < 8; b++) begin
            if (((b ^ (b >> 1)) & 7) == g) return b;
        end
        return -1;
    endfunction

    function automatic int ref_gray(input int b);
        return (b ^ (b >> 1)) & 7;
    endfunction

    task automatic model_step(input int rst, input int clr, input int vld, input int g, input int ovf);
        int d;
        int nb;
        m_step = 0;
        if (rst != 0) begin
            m_state = 0; m_last = 0; m_bin = 0; m_lap = 0; m_err = 0; m_ovfm = 0;
        end else if (clr != 0) begin
            m_state = 0; m_last = 0; m_lap = 0; m_err = 0; m_ovfm = 0;
        end else if (vld != 0) begin
            if (m_state == 0) begin
                m_last = g; m_bin = ref_bin(g); m_state = 1;
            end else if (m_state == 1) begin
                d = $countones((g ^ m_last) & 7);
                if (d == 1) begin
                    nb = ref_bin(g);
                    if (m_bin == 7 && nb == 0) begin
                        if (m_lap < 3) m_lap++;
                        if (ovf == 0) m_ovfm = 1;
                    end
                    m_bin = nb; m_last = g;
                end else if (d > 1) begin
                    m_step = 1; m_err = 1; m_state = 2;
                end
            end
        end
    endtask

    task automatic drive(input logic rst, input logic clr, input logic vld, input int g, input logic ovf);
        exp_t e;
        exp_t o;
        Reset   = rst;
        Clear   = clr;
        Valid   = vld;
        Gray_in = g[2:0];
        Ovf_in  = ovf;
        model_step(int'(rst), int'(clr), int'(vld), g, int'(ovf));
        e.bin = m_bin; e.locked = (m_state == 1) ? 1 : 0; e.step = m_step;
        e.err = m_err; e.ovfm = m_ovfm; e.lap = m_lap;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            chk_eq("queue_underflow", 0, 1);
        end else begin
            o = exp_q.pop_front();
            chk_eq("Binary",       int'(Binary),       o.bin);
            chk_eq("Locked",       int'(Locked),       o.locked);
            chk_eq("Step_err",     int'(Step_err),     o.step);
            chk_eq("Err_sticky",   int'(Err_sticky),   o.err);
            chk_eq("Ovf_mismatch", int'(Ovf_mismatch), o.ovfm);
            chk_eq("Lap_cnt",      int'(Lap_cnt),      o.lap);
        end
    endtask

    initial begin
        int gseq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
        Reset = 1'b1; Clear = 1'b0; Valid = 1'b0; Gray_in = 3'd0; Ovf_in = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 5, 1'b1);

        // Full upward count 0..7.
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, gseq[i], 1'b0);
        // Wrap with Overflow set, then a full lap and a wrap without it.
        drive(1'b0, 1'b0, 1'b1, 0, 1'b1);
        for (int i = 1; i < 8; i++) drive(1'b0, 1'b0, 1'b1, gseq[i], 1'b0);
        drive(1'b0, 1'b0, 1'b1, 0, 1'b0);

        // Two-bit jump 001->111, then ignored samples in ERROR.
        drive(1'b0, 1'b0, 1'b1, 1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 7, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 7, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 0, 1'b0);

        // Clear with a coincident Valid, then relock.
        drive(1'b0, 1'b1, 1'b1, 3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3, 1'b0);

        // Stalls with gaps, Ovf_in high without wrap, then a downward step.
        drive(1'b0, 1'b0, 1'b1, 2, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3, 1'b0);

        // Down to 0, the 0->7 single-bit step (no lap), then a real wrap.
        drive(1'b0, 1'b0, 1'b1, 1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 4, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 0, 1'b1);

        // Five more laps with random idle gaps: lap counter saturates.
        for (int w = 0; w < 5; w++) begin
            for (int b = 1; b <= 8; b++) begin
                if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'b0, ref_gray(b % 8), 1'b0);
                drive(1'b0, 1'b0, 1'b1, ref_gray(b % 8), 1'b1);
            end
        end

        // Reset mid-sequence with Valid high, then a fresh first sample.
        drive(1'b0, 1'b0, 1'b1, 1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 3, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 6, 1'b0);

        if (exp_q.size() != 0) chk_eq("queue_leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
